delay_mem_scheduler: RTL and testbench

//  Shares one single-port delay-buffer RAM between N_REQ requesters (e.g. delay_master, host readback)

---
 rtl/delay_mem_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_delay_mem_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_mem_scheduler.sv
// Round-robin sharing of one single-port delay RAM plus a zero-fill clear sequencer.
// Define DELAY_SCHED_STATS_EN to add the grant_count / stall_count outputs.
module delay_mem_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int N_REQ      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear_req,
  output logic                        clearing,
  input  logic [N_REQ-1:0]            rd_req,
  input  logic [N_REQ-1:0]            wr_req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            rd_valid,
  output logic [N_REQ-1:0]            wr_ack,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata
`ifdef DELAY_SCHED_STATS_EN
  ,
  output logic [31:0]                 grant_count,
  output logic [31:0]                 stall_count
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t state;
  state_t state_n;

  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_n;
  logic [IW-1:0]         rr;
  logic [IW-1:0]         rr_n;

  logic [N_REQ-1:0]      busy;
  logic [N_REQ-1:0]      elig;
  logic [N_REQ-1:0]      gnt_oh;
  logic                  can_grant;
  logic                  gnt_any;
  logic [IW-1:0]         gnt_id;
  logic                  gnt_we;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;

  logic                  en_n;
  logic                  we_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;

  // s1: op on the RAM port this cycle; s2: read data arriving on mem_rdata
  logic                  s1_vld;
  logic                  s1_we;
  logic [IW-1:0]         s1_id;
  logic                  s2_vld;
  logic [IW-1:0]         s2_id;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] id);
    logic [N_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      v[i] = (id == IW'(i));
    end
    return v;
  endfunction

  assign clearing = (state == S_CLEAR);

  // A requester stays masked until its ack / read data has been delivered
  assign busy = (s1_vld ? onehot(s1_id) : '0)
              | (s2_vld ? onehot(s2_id) : '0)
              | rd_valid;

  assign elig      = (rd_req | wr_req) & ~busy;
  assign can_grant = (state == S_IDLE) && !clear_req;
  assign gnt_oh    = gnt_any ? onehot(gnt_id) : '0;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && can_grant && elig[i] && (IW'(i) >= rr)) begin
        gnt_any = 1'b1;
        gnt_id  = IW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && can_grant && elig[i] && (IW'(i) < rr)) begin
        gnt_any = 1'b1;
        gnt_id  = IW'(i);
      end
    end
  end

  // Write wins when a requester holds both; its read is granted later
  always_comb begin
    gnt_we    = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id == IW'(i)) begin
        gnt_we    = wr_req[i];
        gnt_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rr_n = rr;
    if (gnt_any) begin
      if (gnt_id == IW'(N_REQ - 1)) begin
        rr_n = '0;
      end else begin
        rr_n = gnt_id + IW'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    en_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = '0;
    wdata_n = '0;
    unique case (state)
      S_IDLE: begin
        if (clear_req) begin
          state_n = S_CLEAR;
          cnt_n   = '0;
          en_n    = 1'b1;
          we_n    = 1'b1;
        end else if (gnt_any) begin
          en_n    = 1'b1;
          we_n    = gnt_we;
          addr_n  = gnt_addr;
          wdata_n = gnt_we ? gnt_wdata : '0;
        end
      end
      S_CLEAR: begin
        if (cnt == LAST_ADDR) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n  = cnt + ADDR_WIDTH'(1);
          en_n   = 1'b1;
          we_n   = 1'b1;
          addr_n = cnt + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      rr        <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      s1_vld    <= 1'b0;
      s1_we     <= 1'b0;
      s1_id     <= '0;
      s2_vld    <= 1'b0;
      s2_id     <= '0;
      wr_ack    <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
    end else begin
      cnt       <= cnt_n;
      rr        <= rr_n;
      mem_en    <= en_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      s1_vld    <= gnt_any;
      s1_we     <= gnt_we;
      s1_id     <= gnt_id;
      s2_vld    <= s1_vld && !s1_we;
      s2_id     <= s1_id;
      wr_ack    <= (gnt_any && gnt_we) ? onehot(gnt_id) : '0;
      rd_valid  <= s2_vld ? onehot(s2_id) : '0;
      if (s2_vld) begin
        rd_data <= mem_rdata;
      end
    end
  end

`ifdef DELAY_SCHED_STATS_EN
  logic stall;

  assign stall = (|elig) && (|(elig & ~gnt_oh));

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count <= '0;
      stall_count <= '0;
    end else begin
      grant_count <= grant_count + 32'(gnt_any);
      stall_count <= stall_count + 32'(stall);
    end
  end
`else
  logic unused_gnt_oh;

  assign unused_gnt_oh = ^gnt_oh;
`endif

endmodule

// File: tb/tb_delay_mem_scheduler.sv
// Bench for delay_mem_scheduler: directed literal cases plus randomized
// requesters checked each cycle against a grant/latency reference model.
module tb_delay_mem_scheduler;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int N     = 3;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            clear_req = 1'b0;
  logic            clearing;
  logic [N-1:0]    rd_req = '0;
  logic [N-1:0]    wr_req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    rd_valid;
  logic [N-1:0]    wr_ack;
  logic [DW-1:0]   rd_data;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  delay_mem_scheduler #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .N_REQ(N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear_req(clear_req),
    .clearing(clearing),
    .rd_req(rd_req),
    .wr_req(wr_req),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rd_valid(rd_valid),
    .wr_ack(wr_ack),
    .rd_data(rd_data),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: expected outputs per future cycle in a ring
  logic          e_en  [8];
  logic          e_we  [8];
  logic [AW-1:0] e_addr[8];
  logic [DW-1:0] e_wd  [8];
  logic          e_clr [8];
  logic [N-1:0]  e_ack [8];
  logic [N-1:0]  e_rv  [8];
  logic [DW-1:0] e_rd  [8];
  logic [DW-1:0] mm    [DEPTH];
  int busy_until[N];
  int rr_m = 0;
  int clr_start = -1000;
  int t = 0;

  task automatic clear_slot(input int s);
    e_en[s] = 1'b0; e_we[s] = 1'b0; e_addr[s] = '0; e_wd[s] = '0;
    e_clr[s] = 1'b0; e_ack[s] = '0; e_rv[s] = '0; e_rd[s] = '0;
  endtask

  always @(negedge clk) begin
    int s, s1, s3, g, j, k;
    logic [AW-1:0] a;
    logic in_clr;
    s = t % 8;
    chk("mem_en", 32'(mem_en), 32'(e_en[s]));
    chk("clearing", 32'(clearing), 32'(e_clr[s]));
    chk("wr_ack", 32'(wr_ack), 32'(e_ack[s]));
    chk("rd_valid", 32'(rd_valid), 32'(e_rv[s]));
    if (e_en[s]) begin
      chk("mem_we", 32'(mem_we), 32'(e_we[s]));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr[s]));
      if (e_we[s]) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd[s]));
    end
    if (e_rv[s] != '0) chk("rd_data", 32'(rd_data), 32'(e_rd[s]));
    clear_slot(s);
    s1 = (t + 1) % 8;
    s3 = (t + 3) % 8;
    if (reset) begin
      for (int i = 0; i < 8; i++) clear_slot(i);
      for (int i = 0; i < N; i++) busy_until[i] = -1;
      rr_m = 0;
      clr_start = -1000;
    end else begin
      in_clr = (t >= clr_start + 1) && (t <= clr_start + DEPTH);
      if (!in_clr && clear_req) begin
        clr_start = t;
      end else if (!in_clr) begin
        g = -1;
        for (int q = 0; q < N; q++) begin
          j = (rr_m + q) % N;
          if (g < 0 && (rd_req[j] || wr_req[j]) && t > busy_until[j]) g = j;
        end
        if (g >= 0) begin
          rr_m = (g + 1) % N;
          a = req_addr[g*AW +: AW];
          e_en[s1] = 1'b1;
          e_addr[s1] = a;
          if (wr_req[g]) begin
            e_we[s1] = 1'b1;
            e_wd[s1] = req_wdata[g*DW +: DW];
            e_ack[s1] = N'(1) << g;
            mm[a] = req_wdata[g*DW +: DW];
            busy_until[g] = t + 1;
          end else begin
            e_rv[s3] = N'(1) << g;
            e_rd[s3] = mm[a];
            busy_until[g] = t + 3;
          end
        end
      end
      if ((t + 1 >= clr_start + 1) && (t + 1 <= clr_start + DEPTH)) begin
        k = t - clr_start;
        e_en[s1] = 1'b1;
        e_we[s1] = 1'b1;
        e_addr[s1] = AW'(k);
        e_wd[s1] = '0;
        e_clr[s1] = 1'b1;
        mm[k] = '0;
      end
    end
    t++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] p_ack, p_rv, dropped;
  int n0, n1, alt_bad, last_a, clr_hi;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0;
      mm[i] = '0;
    end
    for (int i = 0; i < 8; i++) clear_slot(i);
    for (int i = 0; i < N; i++) busy_until[i] = -1;

    repeat (3) step();
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_clearing", 32'(clearing), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_wr_ack", 32'(wr_ack), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;
    step();

    // Write 0x1234 to addr 5
    wr_req[0] = 1'b1;
    req_addr[AW-1:0] = 4'h5;
    req_wdata[DW-1:0] = 16'h1234;
    step();
    chk("t1_mem_en", 32'(mem_en), 32'h1);
    chk("t1_mem_we", 32'(mem_we), 32'h1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h5);
    chk("t1_mem_wdata", 32'(mem_wdata), 32'h1234);
    chk("t1_wr_ack", 32'(wr_ack), 32'h1);
    step();
    chk("t1_no_regrant", 32'(mem_en), 32'h0);
    wr_req[0] = 1'b0;
    rd_req[0] = 1'b1;
    step();
    chk("t2_mem_en", 32'(mem_en), 32'h1);
    chk("t2_mem_we", 32'(mem_we), 32'h0);
    chk("t2_mem_addr", 32'(mem_addr), 32'h5);
    step();
    chk("t2_rv_early", 32'(rd_valid), 32'h0);
    step();
    chk("t2_rd_valid", 32'(rd_valid), 32'h1);
    chk("t2_rd_data", 32'(rd_data), 32'h1234);
    step();
    rd_req[0] = 1'b0;

    // Requester 1 read+write same address: write first
    step();
    rd_req[1] = 1'b1;
    wr_req[1] = 1'b1;
    req_addr[AW +: AW] = 4'hA;
    req_wdata[DW +: DW] = 16'hBEEF;
    step();
    chk("t4_wr_ack", 32'(wr_ack), 32'h2);
    chk("t4_mem_addr", 32'(mem_addr), 32'hA);
    chk("t4_rv_none", 32'(rd_valid), 32'h0);
    step();
    wr_req[1] = 1'b0;
    step();
    chk("t4_rd_issue", 32'({mem_en, mem_we}), 32'h2);
    step();
    step();
    chk("t4_rd_valid", 32'(rd_valid), 32'h2);
    chk("t4_rd_data", 32'(rd_data), 32'hBEEF);
    step();
    rd_req[1] = 1'b0;

    // Two continuous readers must alternate
    step();
    req_addr[AW-1:0] = 4'h1;
    req_addr[AW +: AW] = 4'h2;
    p_rv = '0;
    n0 = 0; n1 = 0; alt_bad = 0; last_a = -1;
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < 2; i++) rd_req[i] = !p_rv[i];
      step();
      p_rv = rd_valid;
      if (rd_valid[0]) n0++;
      if (rd_valid[1]) n1++;
      if (mem_en && !mem_we) begin
        if (int'(mem_addr) == last_a) alt_bad++;
        last_a = int'(mem_addr);
      end
    end
    rd_req = '0;
    repeat (5) step();
    chk("t3_alternate", 32'(alt_bad), 32'h0);
    chk("t3_req0_served", 32'(n0 >= 15), 32'h1);
    chk("t3_req1_served", 32'(n1 >= 15), 32'h1);

    // Randomized requesters with occasional clear and reset
    p_ack = '0;
    p_rv = '0;
    for (int c = 0; c < 2500; c++) begin
      step();
      reset = 1'b0;
      dropped = '0;
      for (int i = 0; i < N; i++) begin
        if (p_ack[i]) begin wr_req[i] = 1'b0; dropped[i] = 1'b1; end
        if (p_rv[i]) begin rd_req[i] = 1'b0; dropped[i] = 1'b1; end
        if (!dropped[i] && !rd_req[i] && !wr_req[i] &&
            $urandom_range(3) == 0) begin
          case ($urandom_range(3))
            0, 1: rd_req[i] = 1'b1;
            2: wr_req[i] = 1'b1;
            default: begin rd_req[i] = 1'b1; wr_req[i] = 1'b1; end
          endcase
          req_addr[i*AW +: AW] = AW'($urandom_range(DEPTH - 1));
          req_wdata[i*DW +: DW] = DW'($urandom);
        end
      end
      p_ack = wr_ack;
      p_rv = rd_valid;
      clear_req = ($urandom_range(399) == 0);
      if ($urandom_range(699) == 0) begin
        reset = 1'b1;
        clear_req = 1'b0;
        rd_req = '0;
        wr_req = '0;
        p_ack = '0;
        p_rv = '0;
      end
    end
    step();
    reset = 1'b0;
    clear_req = 1'b0;
    rd_req = '0;
    wr_req = '0;
    repeat (6) step();

    // Clear with a pending read; a second clear_req mid-clear is ignored
    clear_req = 1'b1;
    rd_req[0] = 1'b1;
    req_addr[AW-1:0] = 4'h3;
    clr_hi = 0;
    for (int k = 0; k < DEPTH; k++) begin
      step();
      clear_req = (k == 4);
      if (clearing) clr_hi++;
      chk("t5_clr_addr", 32'({mem_en, mem_we, mem_addr}), 32'({2'b11, AW'(k)}));
    end
    clear_req = 1'b0;
    chk("t5_clr_cycles", 32'(clr_hi), 32'd16);
    step();
    chk("t5_clr_end", 32'(clearing), 32'h0);
    step();
    chk("t5_pend_issue", 32'({mem_en, mem_we, mem_addr}), 32'({2'b10, 4'h3}));
    step();
    step();
    chk("t5_pend_rv", 32'(rd_valid), 32'h1);
    chk("t5_pend_data", 32'(rd_data), 32'h0);
    step();
    rd_req[0] = 1'b0;
    repeat (3) step();

    // Reset while clearing address 7
    clear_req = 1'b1;
    repeat (8) begin
      step();
      clear_req = 1'b0;
    end
    chk("t6_addr7", 32'(mem_addr), 32'h7);
    reset = 1'b1;
    step();
    chk("t6_clearing", 32'(clearing), 32'h0);
    chk("t6_outs", 32'({mem_en, mem_we, mem_addr, wr_ack, rd_valid}), 32'h0);
    reset = 1'b0;
    step();
    chk("t6_idle", 32'({clearing, mem_en}), 32'h0);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
